// File: rtl/spi_cmd_if.sv
// Command-stream / register-bank port bundle for spi_cmd_sequencer.
// The master side drives SPI bytes and bank ready; the slave side is the sequencer.
interface spi_cmd_if #(
  parameter int ADDR_W = 8
);
  logic              SSEL;
  logic [7:0]        cmd;
  logic              cmd_valid;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              pulse_valid;
  logic [ADDR_W-1:0] pulse_addr;
  logic              busy;
  logic              err_opcode;
  logic              err_overrun;
  logic              err_clr;

  modport master (
    output SSEL, cmd, cmd_valid, wr_ready, err_clr,
    input  wr_valid, wr_addr, wr_data, pulse_valid, pulse_addr, busy, err_opcode, err_overrun
  );

  modport slave (
    input  SSEL, cmd, cmd_valid, wr_ready, err_clr,
    output wr_valid, wr_addr, wr_data, pulse_valid, pulse_addr, busy, err_opcode, err_overrun
  );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// Parses each SSEL frame into opcode/address/data, issues burst writes over a
// valid/ready port and single-cycle addressed strobes.
module spi_cmd_sequencer #(
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] OP_WRITE = 8'h02,
  parameter logic [7:0] OP_PULSE = 8'h0F
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_cmd_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, P_ADDR, SKIP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        ssel_pipe_q, ssel_pipe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              pulse_valid_q, pulse_valid_d;
  logic [ADDR_W-1:0] pulse_addr_q, pulse_addr_d;
  logic              err_opcode_q, err_opcode_d;
  logic              err_overrun_q, err_overrun_d;

  logic              frame_end;
  logic              wr_pending;
  logic [ADDR_W-1:0] cmd_addr;

  // Two sync stages then one edge-detect stage; idle-high so reset never fakes an edge.
  assign ssel_pipe_d = {ssel_pipe_q[1:0], bus.SSEL};
  assign frame_end   = ssel_pipe_q[1] & ~ssel_pipe_q[2];

  // A request being accepted this cycle frees the slot for a same-cycle byte.
  assign wr_pending  = wr_valid_q & ~bus.wr_ready;
  assign cmd_addr    = ADDR_W'(bus.cmd);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_valid_d    = wr_pending;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    pulse_valid_d = 1'b0;
    pulse_addr_d  = pulse_addr_q;
    err_opcode_d  = err_opcode_q & ~bus.err_clr;
    err_overrun_d = err_overrun_q & ~bus.err_clr;

    if (frame_end) begin
      state_d = IDLE;
    end else if (bus.cmd_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd == OP_WRITE) begin
            state_d = W_ADDR;
          end else if (bus.cmd == OP_PULSE) begin
            state_d = P_ADDR;
          end else begin
            state_d      = SKIP;
            err_opcode_d = 1'b1;
          end
        end
        W_ADDR: begin
          addr_d  = cmd_addr;
          state_d = W_DATA;
        end
        W_DATA: begin
          if (!wr_pending) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = bus.cmd;
            addr_d     = addr_q + ADDR_W'(1);
          end else begin
            err_overrun_d = 1'b1;
          end
        end
        P_ADDR: begin
          pulse_valid_d = 1'b1;
          pulse_addr_d  = cmd_addr;
          state_d       = SKIP;
        end
        SKIP: state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ssel_pipe_q   <= 3'b111;
      addr_q        <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      pulse_valid_q <= 1'b0;
      pulse_addr_q  <= '0;
      err_opcode_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ssel_pipe_q   <= ssel_pipe_d;
      addr_q        <= addr_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      pulse_valid_q <= pulse_valid_d;
      pulse_addr_q  <= pulse_addr_d;
      err_opcode_q  <= err_opcode_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.pulse_valid = pulse_valid_q;
  assign bus.pulse_addr  = pulse_addr_q;
  assign bus.busy        = (state_q != IDLE) | wr_valid_q;
  assign bus.err_opcode  = err_opcode_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: per-cycle vector table plus hand-written
// sequences for backpressure, overrun, frame-end priority and async reset.
module tb_spi_cmd_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   xfers;

  spi_cmd_if #(.ADDR_W(8)) bus ();

  spi_cmd_sequencer #(.ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         xfers <= 0;
    else if (bus.wr_valid && bus.wr_ready) xfers <= xfers + 1;
  end

  // {wr_valid, wr_addr, wr_data, pulse_valid, pulse_addr, busy, err_opcode, err_overrun}
  typedef struct {
    logic        ssel;
    logic        cv;
    logic [7:0]  cmd;
    logic        clr;
    logic [28:0] exp;
  } vec_t;

  vec_t tv[34];

  function automatic vec_t mv(logic s, logic v, logic [7:0] c, logic cl,
                              logic wv, logic [7:0] a, logic [7:0] d,
                              logic pv, logic [7:0] pa, logic b, logic eo);
    vec_t r;
    r.ssel = s; r.cv = v; r.cmd = c; r.clr = cl;
    r.exp  = {wv, a, d, pv, pa, b, eo, 1'b0};
    return r;
  endfunction

  function automatic logic [28:0] outs();
    return {bus.wr_valid, bus.wr_addr, bus.wr_data, bus.pulse_valid, bus.pulse_addr,
            bus.busy, bus.err_opcode, bus.err_overrun};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] c,
                     input logic r, input logic cl);
    bus.SSEL = s; bus.cmd_valid = v; bus.cmd = c; bus.wr_ready = r; bus.err_clr = cl;
    @(posedge clk); #1;
  endtask

  task automatic frame_end(input logic r);
    repeat (3) cyc(1'b1, 1'b0, 8'h00, r, 1'b0);
  endtask

  int base;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.SSEL = 1'b1; bus.cmd_valid = 1'b0; bus.cmd = 8'h00; bus.wr_ready = 1'b0; bus.err_clr = 1'b0;

    // Tests 1, 2, 4, 5 as one cycle-accurate table (wr_ready held high).
    tv[0]  = mv(0,1,8'h02,0, 0,8'h00,8'h00, 0,8'h00, 1,0);
    tv[1]  = mv(0,1,8'h10,0, 0,8'h00,8'h00, 0,8'h00, 1,0);
    tv[2]  = mv(0,1,8'hAA,0, 1,8'h10,8'hAA, 0,8'h00, 1,0);
    tv[3]  = mv(0,0,8'h00,0, 0,8'h10,8'hAA, 0,8'h00, 1,0);
    tv[4]  = mv(0,1,8'hBB,0, 1,8'h11,8'hBB, 0,8'h00, 1,0);
    tv[5]  = mv(1,0,8'h00,0, 0,8'h11,8'hBB, 0,8'h00, 1,0);
    tv[6]  = mv(1,0,8'h00,0, 0,8'h11,8'hBB, 0,8'h00, 1,0);
    tv[7]  = mv(1,0,8'h00,0, 0,8'h11,8'hBB, 0,8'h00, 0,0);
    tv[8]  = mv(0,1,8'h02,0, 0,8'h11,8'hBB, 0,8'h00, 1,0);
    tv[9]  = mv(0,1,8'hFF,0, 0,8'h11,8'hBB, 0,8'h00, 1,0);
    tv[10] = mv(0,1,8'h01,0, 1,8'hFF,8'h01, 0,8'h00, 1,0);
    tv[11] = mv(0,1,8'h02,0, 1,8'h00,8'h02, 0,8'h00, 1,0);
    tv[12] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h00, 1,0);
    tv[13] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h00, 1,0);
    tv[14] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h00, 0,0);
    tv[15] = mv(0,1,8'h0F,0, 0,8'h00,8'h02, 0,8'h00, 1,0);
    tv[16] = mv(0,1,8'h3C,0, 0,8'h00,8'h02, 1,8'h3C, 1,0);
    tv[17] = mv(0,1,8'h99,0, 0,8'h00,8'h02, 0,8'h3C, 1,0);
    tv[18] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h3C, 1,0);
    tv[19] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h3C, 1,0);
    tv[20] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h3C, 0,0);
    tv[21] = mv(0,1,8'h7E,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[22] = mv(0,1,8'h02,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[23] = mv(0,1,8'h10,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[24] = mv(0,1,8'hAA,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[25] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[26] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[27] = mv(1,0,8'h00,0, 0,8'h00,8'h02, 0,8'h3C, 0,1);
    tv[28] = mv(0,1,8'h02,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[29] = mv(0,1,8'h10,0, 0,8'h00,8'h02, 0,8'h3C, 1,1);
    tv[30] = mv(0,1,8'hAA,0, 1,8'h10,8'hAA, 0,8'h3C, 1,1);
    tv[31] = mv(1,0,8'h00,1, 0,8'h10,8'hAA, 0,8'h3C, 1,0);
    tv[32] = mv(1,0,8'h00,0, 0,8'h10,8'hAA, 0,8'h3C, 1,0);
    tv[33] = mv(1,0,8'h00,0, 0,8'h10,8'hAA, 0,8'h3C, 0,0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("idle_after_reset", 32'(outs()), 32'h0);

    for (int i = 0; i < 34; i++) begin
      cyc(tv[i].ssel, tv[i].cv, tv[i].cmd, 1'b1, tv[i].clr);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tv[i].exp));
    end
    chk("table_xfers", 32'(xfers), 32'd5);

    // Test 3: backpressure holds the first request; extra bytes overrun.
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    base = xfers;
    chk("bp_req", {23'h0, bus.wr_valid, bus.wr_addr}, {23'h0, 1'b1, 8'h20});
    chk("bp_ovr_clear", 32'(bus.err_overrun), 32'd0);
    cyc(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
    chk("bp_hold", {15'h0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {15'h0, 1'b1, 8'h20, 8'h55});
    chk("bp_overrun", 32'(bus.err_overrun), 32'd1);
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("set_beats_clr", 32'(bus.err_overrun), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("bp_hold2", {15'h0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {15'h0, 1'b1, 8'h20, 8'h55});
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_release", 32'(bus.wr_valid), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_one_xfer", 32'(xfers - base), 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("ovr_cleared", 32'(bus.err_overrun), 32'd0);
    cyc(1'b0, 1'b1, 8'h88, 1'b1, 1'b0);
    chk("addr_not_advanced", {15'h0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {15'h0, 1'b1, 8'h21, 8'h88});
    frame_end(1'b1);
    chk("bp_frame_idle", 32'(bus.busy), 32'd0);

    // Test 6: truncated frame, frame end beats a same-cycle byte, then next opcode.
    base = xfers;
    cyc(1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h40, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("fe_priority", {30'h0, bus.wr_valid, bus.busy}, 32'h0);
    cyc(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    chk("fe_new_opcode", {29'h0, bus.wr_valid, bus.busy, bus.err_opcode}, 32'b011);
    chk("fe_no_write", 32'(xfers - base), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    frame_end(1'b1);

    // Async reset with a write pending.
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("rst_pre_pending", {30'h0, bus.wr_valid, bus.busy}, 32'b11);
    rst_n = 1'b0;
    #2;
    chk("rst_async", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h50, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    chk("rst_opcode_after", {15'h0, bus.wr_valid, bus.wr_addr, bus.wr_data}, {15'h0, 1'b1, 8'h50, 8'h33});
    chk("rst_no_errs", {30'h0, bus.err_opcode, bus.err_overrun}, 32'h0);
    frame_end(1'b1);
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
